// File: rtl/seg_scan_ctrl.sv
// Seven-segment scan controller: refresh divider, digit select, anode drive and
// frame-synchronous display update. Optional anode blanking under `SEG_SCAN_BLANK_EN`.
module seg_scan_ctrl #(
  parameter int DIV_W     = 17,
  parameter int BLANK_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] data_in,
  input  logic        data_valid,
  input  logic [3:0]  digit_en,
  output logic [1:0]  sel,
  output logic [3:0]  num1,
  output logic [3:0]  num2,
  output logic [3:0]  num3,
  output logic [3:0]  num4,
  output logic [3:0]  an,
  output logic        frame_tick,
  output logic        upd_pending
);

  if (DIV_W < 2 || BLANK_CYC < 0 || BLANK_CYC >= (1 << DIV_W)) begin : g_bad_param
    $error("seg_scan_ctrl: DIV_W must be >= 2 and BLANK_CYC < 2**DIV_W");
  end

  logic [DIV_W-1:0] div_cnt;
  logic [15:0]      pend;
  logic             tc;
  logic             boundary;
  logic [1:0]       sel_next;
  logic [3:0]       digit_on;
  logic [3:0]       an_next;

  always_comb begin
    tc       = &div_cnt;
    boundary = en && tc && (sel == 2'd3);
    sel_next = (en && tc) ? sel + 2'd1 : sel;
    // Anode derives from sel_next so both registers change on the same edge.
    digit_on = (4'b0001 << sel_next) & digit_en & {4{en}};
  end

`ifdef SEG_SCAN_BLANK_EN
  logic [DIV_W-1:0] blank_cnt;
  logic [DIV_W-1:0] blank_next;

  // Counter holds the number of dark cycles still owed; reloaded on every sel
  // change and while disabled so re-enabling also starts dark.
  always_comb begin
    if (!en || tc)
      blank_next = DIV_W'(BLANK_CYC);
    else if (blank_cnt != '0)
      blank_next = blank_cnt - DIV_W'(1);
    else
      blank_next = '0;
    an_next = (blank_next != '0) ? 4'hF : ~digit_on;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) blank_cnt <= DIV_W'(BLANK_CYC);
    else        blank_cnt <= blank_next;
  end
`else
  always_comb an_next = ~digit_on;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt     <= '0;
      sel         <= 2'd0;
      an          <= 4'hF;
      frame_tick  <= 1'b0;
      upd_pending <= 1'b0;
      pend        <= '0;
      num1        <= '0;
      num2        <= '0;
      num3        <= '0;
      num4        <= '0;
    end else begin
      if (en) div_cnt <= div_cnt + DIV_W'(1);
      sel        <= sel_next;
      an         <= an_next;
      frame_tick <= boundary;
      // Direct load when dark or on the boundary itself; otherwise defer.
      if (data_valid && (!en || boundary)) begin
        {num4, num3, num2, num1} <= data_in;
        upd_pending              <= 1'b0;
      end else if (data_valid) begin
        pend        <= data_in;
        upd_pending <= 1'b1;
      end else if (boundary && upd_pending) begin
        {num4, num3, num2, num1} <= pend;
        upd_pending              <= 1'b0;
      end
    end
  end

endmodule
